c7b_store_buf: RTL and testbench
================================

# c7b_store_buf

Store buffer and write-channel adapter for the c7b core. It accepts store requests from the execute stage: address, raw register data and size for st.b, st.h and st.w. It aligns the data into byte lanes and generates byte strobes, then queues requests in a small FIFO. It drains the queue as single-beat AXI write transactions, one outstanding at a time, to the bus bridge that fronts data memory. The buffer lets EX retire a store without stalling on bus latency, and `buf_empty` gives the pipeline an ordering point for loads and fences.

## Interface
- `DEPTH`, 2: number of FIFO entries; a power of two, at least 2.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `st_valid`  in  1  EX presents a store request.
- `st_ready`  out  1  the buffer can accept a request; it is asserted when count < DEPTH.
- `st_addr`  in  32  byte address of the store.
- `st_data`  in  32  raw rs data; the least-significant bytes are used.
- `st_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- `st_ale`  out  1  registered one-cycle pulse reporting a misaligned or reserved request.
- `awvalid` / `awready`  out / in  1 / 1  AXI write-address handshake.
- `awaddr`  out  32  the unmodified byte address.
- `awsize`  out  3  equal to {1'b0, size}.
- `wvalid` / `wready`  out / in  1 / 1  AXI write-data handshake.
- `wdata`  out  32  lane-aligned data.
- `wstrb`  out  4  byte strobes.
- `wlast`  out  1  constant 1.
- `bvalid` / `bready`  in / out  1 / 1  AXI write-response handshake.
- `bresp`  in  2  write-response code.
- `bus_err`  out  1  one-cycle pulse when bresp is not 00.
- `buf_empty`  out  1  high when the FIFO is empty and the FSM is in IDLE.

## Operation
- **Request acceptance.** A request is accepted when `st_valid` and `st_ready` are both high at a rising edge.
- **Alignment, computed at enqueue:**
  - byte: wdata = {4{d[7:0]}}, wstrb = 4'b0001 << a[1:0].
  - half: wdata = {2{d[15:0]}}, wstrb = a[1] ? 4'b1100 : 4'b0011.
  - word: wdata = d, wstrb = 4'b1111.
- **Misaligned and reserved requests:**
  - A request is rejected when it is a half with a[0] = 1, a word with a[1:0] ≠ 00, or has size 11.
  - A rejected request is still "accepted" by the handshake but is not enqueued.
  - `st_ale` pulses high in the cycle after the accepting edge.
- **FIFO.** Each entry holds {addr, size, wdata, wstrb}. Read and write pointers wrap modulo DEPTH, and count is held in log2(DEPTH)+1 bits.
  - There is no bypass. A full FIFO holds `st_ready` low even when a pop happens in the same cycle.
  - A push and a pop on the same edge leave count unchanged.
- **Drain FSM:**
  - IDLE: when count ≠ 0, go to SEND and assert `awvalid` and `wvalid` together.
  - SEND: each channel deasserts its valid independently at its own handshake edge. When both handshakes are done, go to WAIT_B.
  - WAIT_B: `bready` = 1. On the `bvalid` handshake, pop the head and go to IDLE. If bresp ≠ 00, also pulse `bus_err` in the next cycle.
  - An errored store is still popped and is not retried.
- **Channel ordering and outputs:**
  - AW and W may complete in either order or on the same edge.
  - `bvalid` is ignored outside WAIT_B.
  - The AW and W outputs are driven from the FIFO head entry while in SEND.
- **Reset.** Asserting `resetn` low clears the pointers and count, moves the FSM to IDLE, and drops all valids. Any in-flight transaction is abandoned.

## Timing
- **Reset values:**
  - st_ready = 1, buf_empty = 1, wlast = 1.
  - awvalid, wvalid, bready, st_ale, bus_err = 0.
  - awaddr, awsize, wdata, wstrb = 0.
- **Enqueue-to-bus latency.** A store accepted at edge E0 into an empty, idle buffer produces awvalid = wvalid = 1 from edge E1.
- **Back-to-back stores.** The next transaction starts at least one cycle after the pop. The FSM passes through IDLE, so there is a one-cycle gap on the bus.
- **Minimum transaction length** with awready = wready = bvalid = 1 is 3 cycles: SEND, WAIT_B, IDLE.
- **Valids stay stable.** awvalid and wvalid stay high, with stable payload, until their handshake, regardless of other inputs.
- **buf_empty.** It falls at the first enqueue edge and rises at the edge of the final pop.

## Test plan
- **Byte store.** Reset, then issue a byte store to 0x1c0001a3 with data 0x0000005a, with awready = wready = bvalid = 1.
  - Expect awaddr 0x1c0001a3, awsize 000, wdata 0x5a5a5a5a, wstrb 1000, with awvalid rising one cycle after acceptance.
  - Expect buf_empty to be high again after the B handshake.
- **Half store.** Issue a half store to 0x1c000102 with data 0x1234abcd.
  - Expect wdata 0xabcdabcd and wstrb 1100.
  - Then issue a word store to 0x1c000104 with data 0xdeadbeef: expect wstrb 1111.
- **Misaligned half.** Issue a half store to 0x1c000101.
  - Expect st_ale high for exactly one cycle, and no awvalid or wvalid.
  - Expect count unchanged and buf_empty to stay 1.
- **Backpressure:**
  - With awready held 0, issue 3 byte stores. Expect st_ready to drop after the second; the third stays pending.
  - Release awready and delay wready by 2 cycles. Expect W to complete after AW, and all three stores to drain in FIFO order.
- **Error response.** Return bresp = 10 for the first store.
  - Expect a one-cycle bus_err pulse, the entry popped, and the second store issued normally.
- **Reset mid-transaction.** Pull resetn low while in SEND with awvalid = 1.
  - Expect awvalid, wvalid and bready to be 0 asynchronously, and st_ready = 1, buf_empty = 1.
  - After release, no stale transaction is issued.

Source files
------------

// File: rtl/c7b_store_buf.sv
// Store buffer: aligns EX stores into byte lanes, queues them, drains as single-beat AXI writes.
// Latency: a store accepted into an empty idle buffer raises awvalid/wvalid one cycle later.
// Backpressure: st_ready drops when the queue is full; AW/W valids hold until their own handshakes.

module sb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module c7b_store_buf #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_ale,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    output logic        bus_err,
    output logic        buf_empty
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] dat;
        logic [3:0]  strb;
    } sb_entry_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_WAIT_B = 2'd2
    } state_t;

    state_t       state;
    sb_entry_t    req;
    sb_entry_t    head;
    logic         misalign;
    logic         accept;
    logic         push;
    logic         pop;
    logic         aw_done;
    logic         w_done;
    logic [CW-1:0] count;

    always_comb begin
        req      = '0;
        misalign = 1'b0;
        req.addr = st_addr;
        req.size = st_size;
        case (st_size)
            2'b00: begin
                req.dat  = {4{st_data[7:0]}};
                req.strb = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                req.dat  = {2{st_data[15:0]}};
                req.strb = st_addr[1] ? 4'b1100 : 4'b0011;
                misalign = st_addr[0];
            end
            2'b10: begin
                req.dat  = st_data;
                req.strb = 4'b1111;
                misalign = |st_addr[1:0];
            end
            default: misalign = 1'b1;
        endcase
    end

    // Rejected requests still complete the handshake so EX never stalls on them.
    assign st_ready  = (count < FULL_CNT);
    assign accept    = st_valid && st_ready;
    assign push      = accept && !misalign;
    assign pop       = (state == S_WAIT_B) && bvalid && bready;
    assign buf_empty = (count == '0) && (state == S_IDLE);
    assign wlast     = 1'b1;

    sb_fifo #(
        .WIDTH ($bits(sb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push_vld (push),
        .push_dat (req),
        .pop_vld  (pop),
        .head_dat (head),
        .count    (count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_ale <= 1'b0;
        end else begin
            st_ale <= accept && misalign;
        end
    end

    // A channel counts as done once its valid has already dropped or it handshakes now.
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid || wready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            bus_err <= 1'b0;
            awaddr  <= '0;
            awsize  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        awaddr  <= head.addr;
                        awsize  <= {1'b0, head.size};
                        wdata   <= head.dat;
                        wstrb   <= head.strb;
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        bus_err <= (bresp != 2'b00);
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    awvalid <= 1'b0;
                    wvalid  <= 1'b0;
                    bready  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_c7b_store_buf.sv
// Directed bench for c7b_store_buf: alignment, rejection, backpressure, error response and reset.
module tb_c7b_store_buf;
    logic        clk;
    logic        resetn;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_ale;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        bus_err;
    logic        buf_empty;

    int checks   = 0;
    int failures = 0;

    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];

    c7b_store_buf #(.DEPTH(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .st_ale    (st_ale),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .awsize    (awsize),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp),
        .bus_err   (bus_err),
        .buf_empty (buf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (awvalid && awready) aw_log.push_back(awaddr);
        if (wvalid && wready)   w_log.push_back(wdata);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; returns 1 time unit after the accepting edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
        step();
        st_valid = 1'b0;
    endtask

    task automatic wait_empty(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (buf_empty) break;
            step();
        end
        chk("drain_empty", {31'd0, buf_empty}, 32'd1);
    endtask

    initial begin
        int seen;
        resetn   = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_size  = '0;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        bresp    = 2'b00;
        #3 resetn = 1'b0;
        #1;
        chk("rst_st_ready",  {31'd0, st_ready},  32'd1);
        chk("rst_buf_empty", {31'd0, buf_empty}, 32'd1);
        chk("rst_wlast",     {31'd0, wlast},     32'd1);
        chk("rst_valids",    {27'd0, awvalid, wvalid, bready, st_ale, bus_err}, 32'd0);
        chk("rst_payload",   awaddr | wdata | {28'd0, wstrb} | {29'd0, awsize}, 32'd0);
        step();
        step();
        resetn = 1'b1;
        step();

        // Byte store, bus always ready
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        store(32'h1c0001a3, 32'h0000005a, 2'b00);
        chk("b_empty_fall", {31'd0, buf_empty}, 32'd0);
        chk("b_aw_not_yet", {31'd0, awvalid},   32'd0);
        step();
        chk("b_awvalid", {31'd0, awvalid}, 32'd1);
        chk("b_wvalid",  {31'd0, wvalid},  32'd1);
        chk("b_awaddr",  awaddr, 32'h1c0001a3);
        chk("b_awsize",  {29'd0, awsize}, 32'd0);
        chk("b_wdata",   wdata, 32'h5a5a5a5a);
        chk("b_wstrb",   {28'd0, wstrb}, 32'h8);
        step();
        chk("b_bready",  {31'd0, bready}, 32'd1);
        step();
        chk("b_empty_rise", {31'd0, buf_empty}, 32'd1);

        // Half then word
        store(32'h1c000102, 32'h1234abcd, 2'b01);
        step();
        chk("h_wdata",  wdata, 32'habcdabcd);
        chk("h_wstrb",  {28'd0, wstrb}, 32'hc);
        chk("h_awsize", {29'd0, awsize}, 32'd1);
        wait_empty(20);
        store(32'h1c000104, 32'hdeadbeef, 2'b10);
        step();
        chk("w_wstrb",  {28'd0, wstrb}, 32'hf);
        chk("w_wdata",  wdata, 32'hdeadbeef);
        chk("w_awsize", {29'd0, awsize}, 32'd2);
        wait_empty(20);

        // Misaligned half and reserved size
        store(32'h1c000101, 32'h00001111, 2'b01);
        chk("ale_pulse",   {31'd0, st_ale},    32'd1);
        chk("ale_empty",   {31'd0, buf_empty}, 32'd1);
        step();
        chk("ale_one_cyc", {31'd0, st_ale},    32'd0);
        chk("ale_no_bus",  {30'd0, awvalid, wvalid}, 32'd0);
        chk("ale_empty2",  {31'd0, buf_empty}, 32'd1);
        chk("ale_ready",   {31'd0, st_ready},  32'd1);
        store(32'h1c000100, 32'h00002222, 2'b11);
        chk("rsv_ale",     {31'd0, st_ale},    32'd1);
        step();
        chk("rsv_no_bus",  {31'd0, awvalid},   32'd0);

        // Backpressure: AW held off, W delayed after AW release
        aw_log.delete();
        w_log.delete();
        awready = 1'b0; wready = 1'b0;
        store(32'h1c000200, 32'h00000011, 2'b00);
        store(32'h1c000201, 32'h00000022, 2'b00);
        chk("bp_full", {31'd0, st_ready}, 32'd0);
        st_valid = 1'b1;
        st_addr  = 32'h1c000202;
        st_data  = 32'h00000033;
        st_size  = 2'b00;
        step(); step(); step();
        chk("bp_still_full", {31'd0, st_ready}, 32'd0);
        chk("bp_aw_hold",    {31'd0, awvalid},  32'd1);
        chk("bp_aw_stable",  awaddr, 32'h1c000200);
        awready = 1'b1;
        step();
        chk("bp_aw_first", {30'd0, awvalid, wvalid}, 32'd1);
        step();
        chk("bp_w_wait",   {31'd0, wvalid}, 32'd1);
        wready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (st_ready) break;
            step();
        end
        chk("bp_ready_back", {31'd0, st_ready}, 32'd1);
        step();
        st_valid = 1'b0;
        wait_empty(40);
        chk("bp_aw_count", aw_log.size(), 32'd3);
        chk("bp_w_count",  w_log.size(),  32'd3);
        if (aw_log.size() == 3 && w_log.size() == 3) begin
            chk("bp_aw0", aw_log[0], 32'h1c000200);
            chk("bp_aw1", aw_log[1], 32'h1c000201);
            chk("bp_aw2", aw_log[2], 32'h1c000202);
            chk("bp_w0",  w_log[0],  32'h11111111);
            chk("bp_w2",  w_log[2],  32'h33333333);
        end

        // Error response on the first of two stores
        bresp = 2'b10;
        store(32'h1c000300, 32'h00000044, 2'b00);
        store(32'h1c000304, 32'hcafef00d, 2'b10);
        step();
        chk("err_not_yet", {31'd0, bus_err}, 32'd0);
        step();
        chk("err_pulse",   {31'd0, bus_err}, 32'd1);
        bresp = 2'b00;
        step();
        chk("err_one_cyc", {31'd0, bus_err}, 32'd0);
        chk("err_next_aw", {31'd0, awvalid}, 32'd1);
        chk("err_next_addr", awaddr, 32'h1c000304);
        wait_empty(20);
        chk("err_clean", {31'd0, bus_err}, 32'd0);

        // Reset while in SEND
        awready = 1'b0; wready = 1'b0;
        store(32'h1c000400, 32'h00000055, 2'b00);
        step();
        chk("mr_in_send", {31'd0, awvalid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("mr_valids",  {29'd0, awvalid, wvalid, bready}, 32'd0);
        chk("mr_ready",   {31'd0, st_ready},  32'd1);
        chk("mr_empty",   {31'd0, buf_empty}, 32'd1);
        step();
        resetn = 1'b1;
        awready = 1'b1; wready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (awvalid || wvalid) seen++;
        end
        chk("mr_no_stale", seen, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
